alu_seq_exec: RTL and testbench

Sequential execute unit that directly consumes the 4-bit `alu_ctrl` code from the ALU control decoder and produces the datapath result. It computes add, sub, and the logic ops in one cycle. Shifts run on an iterative shifter with a start/busy/done handshake. It sits between the ALU control decoder / operand muxes and the writeback mux. The core stalls on `busy`.

---
 rtl/alu_seq_exec.sv | 126 ++++++++++++
 tb/tb_alu_seq_exec.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Sequential ALU execute stage: single-cycle add/sub/logic, iterative shifter with start/busy/done.
// Optional macro ALU_SEQ_MULTISHIFT_EN lets each shift cycle move up to 4 bits instead of 1.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic {IDLE, SHIFT} state_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_e;

  state_e           state_q;
  shkind_e          kind_q;
  shkind_e          kindIn;
  logic [WIDTH-1:0] shreg_q;
  logic [SHW-1:0]   cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic [SHW-1:0]   shAmt;
  logic [WIDTH-1:0] aluRes;
  logic             needShift;
  logic [2:0]       step;
  logic [WIDTH-1:0] shNext;

  assign shAmt = op_b[SHW-1:0];

  always_comb begin
    aluRes    = '0;
    needShift = 1'b0;
    kindIn    = SH_LL;
    case (alu_ctrl)
      4'b0000: aluRes = op_a + op_b;
      4'b0001: aluRes = op_a - op_b;
      4'b0010: begin aluRes = op_a; needShift = (shAmt != '0); kindIn = SH_LL; end
      4'b0011: begin aluRes = op_a; needShift = (shAmt != '0); kindIn = SH_RL; end
      4'b0100: begin aluRes = op_a; needShift = (shAmt != '0); kindIn = SH_RA; end
      4'b0101: aluRes = op_a & op_b;
      4'b0110: aluRes = op_a | op_b;
      4'b0111: aluRes = op_a ^ op_b;
      default: aluRes = '0;
    endcase
  end

`ifdef ALU_SEQ_MULTISHIFT_EN
  assign step = (cnt_q > SHW'(4)) ? 3'd4 : cnt_q[2:0];
`else
  assign step = 3'd1;
`endif

  always_comb begin
    shNext = shreg_q;
    case (kind_q)
      SH_LL:   shNext = shreg_q << step;
      SH_RL:   shNext = shreg_q >> step;
      SH_RA:   shNext = $unsigned($signed(shreg_q) >>> step);
      default: shNext = shreg_q;
    endcase
  end

  // Counter holds remaining bits; the edge that drains it also publishes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kind_q   <= SH_LL;
      shreg_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (needShift) begin
              shreg_q <= op_a;
              cnt_q   <= shAmt;
              kind_q  <= kindIn;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end else begin
              result_q <= aluRes;
              zero_q   <= (aluRes == '0);
              done_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg_q <= shNext;
          cnt_q   <= cnt_q - SHW'(step);
          if (cnt_q == SHW'(step)) begin
            result_q <= shNext;
            zero_q   <= (shNext == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus random ops against an arithmetic model.
// Honours ALU_SEQ_MULTISHIFT_EN when computing expected shift latency.
module tb_alu_seq_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int nChecks = 0;
  int nFails  = 0;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [3:0] c,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    start    = s;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: result from plain arithmetic, latency from the shift distance.
  task automatic modelOp(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat);
    int n;
    logic signed [W-1:0] sa;
    n   = int'(b % W);
    sa  = a;
    lat = 1;
    case (c)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a << n;
      4'd3: res = a >> n;
      4'd4: res = sa >>> n;
      4'd5: res = a & b;
      4'd6: res = a | b;
      4'd7: res = a ^ b;
      default: res = '0;
    endcase
    if (c >= 4'd2 && c <= 4'd4 && n > 0) begin
`ifdef ALU_SEQ_MULTISHIFT_EN
      lat = (n + 3) / 4 + 1;
`else
      lat = n + 1;
`endif
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] c,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] expRes;
    int expLat;
    int lat;
    modelOp(c, a, b, expRes, expLat);
    applyStimulus(1'b1, c, a, b);
    tick();
    applyStimulus(1'b0, 4'd0, '0, '0);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
      tick();
      lat++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_res"}, 64'(result), 64'(expRes));
    checkOutput({tag, "_zero"}, 64'(zero), 64'(expRes == '0));
    checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int doneCount;
    int shiftLat;
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, '0, '0);
    repeat (2) tick();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    runOp("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1);
    runOp("sub_zero", 4'd1, 32'd5, 32'd5);
    runOp("xor", 4'd7, 32'hF0F0_F0F0, 32'hFFFF_0000);
    runOp("sra31", 4'd4, 32'h8000_0000, 32'd31);
    runOp("srl31", 4'd3, 32'h8000_0000, 32'd31);
    runOp("sll0", 4'd2, 32'h1, 32'd0);
    runOp("undef", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start held while busy must be dropped; only the shift completes.
    applyStimulus(1'b1, 4'd2, 32'h0000_00A5, 32'd8);
    tick();
    doneCount = 0;
    shiftLat  = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 2) applyStimulus(1'b1, 4'd0, 32'd3, 32'd4);
      else        applyStimulus(1'b0, 4'd0, '0, '0);
      if (done === 1'b1) begin
        doneCount++;
        shiftLat = i;
      end
      tick();
    end
    checkOutput("drop_count", 64'(doneCount), 64'd1);
`ifdef ALU_SEQ_MULTISHIFT_EN
    checkOutput("drop_lat", 64'(shiftLat), 64'd3);
`else
    checkOutput("drop_lat", 64'(shiftLat), 64'd9);
`endif
    checkOutput("drop_res", 64'(result), 64'h0000_A500);

    applyStimulus(1'b1, 4'd0, 32'd10, 32'd20);
    tick();
    checkOutput("b2b_add_done", 64'(done), 64'd1);
    checkOutput("b2b_add_res", 64'(result), 64'd30);
    applyStimulus(1'b1, 4'd6, 32'hF000_0000, 32'h0000_000F);
    tick();
    checkOutput("b2b_or_done", 64'(done), 64'd1);
    checkOutput("b2b_or_res", 64'(result), 64'hF000_000F);
    applyStimulus(1'b1, 4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F);
    tick();
    checkOutput("b2b_and_done", 64'(done), 64'd1);
    checkOutput("b2b_and_res", 64'(result), 64'h0F00_0F00);
    applyStimulus(1'b0, 4'd0, '0, '0);
    tick();
    checkOutput("b2b_idle_done", 64'(done), 64'd0);
    checkOutput("b2b_hold_res", 64'(result), 64'h0F00_0F00);

    // Asynchronous reset mid-shift discards the op.
    applyStimulus(1'b1, 4'd2, 32'h1, 32'd20);
    tick();
    applyStimulus(1'b0, 4'd0, '0, '0);
    repeat (4) tick();
    checkOutput("midrst_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_result", 64'(result), 64'd0);
    checkOutput("midrst_zero", 64'(zero), 64'd1);
    checkOutput("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) doneCount++;
    end
    checkOutput("midrst_no_done", 64'(doneCount), 64'd0);

    for (int k = 0; k < 40; k++) begin
      runOp("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] simulation timeout");
  end
endmodule
